// File: rtl/s2p_pkg.sv
// rtl/s2p_pkg.sv - shared defaults, derived sizes and output FSM state type for multi_ch_s2p
package s2p_pkg;

    localparam int S2P_DATA_WIDTH = 8;
    localparam int S2P_SIZE_DEF   = 3;
    localparam int S2P_NUM_CH     = 2;
    localparam int S2P_N          = S2P_SIZE_DEF * S2P_SIZE_DEF;
    localparam int S2P_CNT_W      = $clog2(S2P_N);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // A one-element frame still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/s2p_shift_chan.sv
// rtl/s2p_shift_chan.sv - one channel's element shift register with zero-pad substitution
module s2p_shift_chan
    import s2p_pkg::*;
#(
    parameter int DATA_WIDTH = S2P_DATA_WIDTH,
    parameter int N          = S2P_N
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      shift_en_i,
    input  logic                      pad_zero_i,
    input  logic [DATA_WIDTH-1:0]     elem_i,
    output logic [N*DATA_WIDTH-1:0]   buf_o,
    output logic [N*DATA_WIDTH-1:0]   buf_next_o
);

    logic [N*DATA_WIDTH-1:0] buf_q;
    logic [N*DATA_WIDTH-1:0] buf_d;
    logic [DATA_WIDTH-1:0]   elem;

    // Newest element enters slice 0, so the oldest beat ends up in the top slice.
    always_comb begin
        elem  = pad_zero_i ? '0 : elem_i;
        buf_d = buf_q;
        if (shift_en_i) begin
            buf_d                   = buf_q << DATA_WIDTH;
            buf_d[DATA_WIDTH-1:0]   = elem;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign buf_o      = buf_q;
    assign buf_next_o = buf_d;

endmodule

// File: rtl/multi_ch_s2p.sv
// rtl/multi_ch_s2p.sv - multi-channel serial-to-parallel framer with one-deep output register
module multi_ch_s2p
    import s2p_pkg::*;
#(
    parameter int DATA_WIDTH = S2P_DATA_WIDTH,
    parameter int S2P_SIZE   = S2P_SIZE_DEF,
    parameter int NUM_CH     = S2P_NUM_CH
) (
    input  logic                                            clk,
    input  logic                                            rstn,
    input  logic                                            start,
    input  logic                                            clear,
    input  logic                                            in_valid,
    output logic                                            in_ready,
    input  logic [NUM_CH-1:0]                               pad_zero,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                    in_data,
    output logic                                            out_valid,
    input  logic                                            out_ready,
    output logic [NUM_CH*S2P_SIZE*S2P_SIZE*DATA_WIDTH-1:0]  out_data,
    output logic [7:0]                                      out_frame_id
);

    localparam int N     = S2P_SIZE * S2P_SIZE;
    localparam int CNT_W = cnt_width(N);
    localparam int FW    = N * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   accept;
    logic                   capture;
    logic [NUM_CH*FW-1:0]   frame_next;
    logic [NUM_CH*FW-1:0]   out_data_q;
    logic [7:0]             frame_id_q;
    logic                   out_valid_q;
    logic                   seen_frame_q;
    out_state_e             state_q;

    // The last beat is held off only when it would overwrite a frame nobody has taken.
    assign in_ready = !rstn && start && !clear
                      && !(cnt_q == LAST && out_valid_q && !out_ready);
    assign accept   = in_valid && in_ready;
    assign capture  = accept && (cnt_q == LAST);

    genvar c;
    generate
        for (c = 0; c < NUM_CH; c++) begin : g_chan
            logic [FW-1:0] buf_unused;
            s2p_shift_chan #(
                .DATA_WIDTH (DATA_WIDTH),
                .N          (N)
            ) u_chan (
                .clk        (clk),
                .rstn       (rstn),
                .shift_en_i (accept),
                .pad_zero_i (pad_zero[c]),
                .elem_i     (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
                .buf_o      (buf_unused),
                .buf_next_o (frame_next[c*FW +: FW])
            );
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q      <= ST_EMPTY;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            frame_id_q   <= '0;
            seen_frame_q <= 1'b0;
        end else begin
            if (capture) begin
                state_q      <= ST_FULL;
                out_valid_q  <= 1'b1;
                out_data_q   <= frame_next;
                frame_id_q   <= seen_frame_q ? frame_id_q + 8'd1 : 8'd0;
                seen_frame_q <= 1'b1;
            end else if (state_q == ST_FULL && out_ready) begin
                state_q     <= ST_EMPTY;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_frame_id = frame_id_q;

endmodule

// File: tb/tb_multi_ch_s2p.sv
// tb/tb_multi_ch_s2p.sv - directed self-checking bench for multi_ch_s2p
module tb_multi_ch_s2p;

    localparam int DW = 8;
    localparam int N  = 9;
    localparam int W  = 2 * N * DW;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    pad_zero;
    logic [15:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [7:0]    out_frame_id;

    int errors = 0;
    int checks = 0;

    logic [7:0]    v0 [N];
    logic [7:0]    v1 [N];
    logic [1:0]    pz [N];
    logic [W-1:0]  exp_a;

    always #5 clk = ~clk;

    multi_ch_s2p #(.DATA_WIDTH(8), .S2P_SIZE(3), .NUM_CH(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pad_zero     (pad_zero),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_frame_id (out_frame_id)
    );

    task automatic fill(input logic [7:0] b0, input logic [7:0] b1);
        for (int k = 0; k < N; k++) begin
            v0[k] = b0 + 8'(k);
            v1[k] = b1 + 8'(k);
            pz[k] = 2'b00;
        end
    endtask

    // First beat of a frame lands in the top slice of each channel.
    function automatic logic [W-1:0] exp_frame();
        logic [W-1:0] e;
        e = '0;
        for (int k = 0; k < N; k++) begin
            e[(N-1-k)*DW +: DW]        = pz[k][0] ? 8'h00 : v0[k];
            e[N*DW + (N-1-k)*DW +: DW] = pz[k][1] ? 8'h00 : v1[k];
        end
        return e;
    endfunction

    task automatic send_beat(input int k);
        in_valid = 1'b1;
        in_data  = {v1[k], v0[k]};
        pad_zero = pz[k];
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        pad_zero = 2'($urandom);
    endtask

    task automatic send_range(input int a, input int b);
        for (int k = a; k <= b; k++) send_beat(k);
    endtask

    task automatic test_reset();
        rstn = 1'b1; start = 1'b1; clear = 1'b0; in_valid = 1'b0;
        out_ready = 1'b1; pad_zero = 2'b00; in_data = 16'h0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        checks++; if (out_frame_id !== 8'd0) begin errors++; $display("FAIL reset_frame_id got=%0d exp=0", out_frame_id); end
        rstn = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill(8'h01, 8'h11);
        send_range(0, 7);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        send_beat(8);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_frame()) begin errors++; $display("FAIL basic_data got=%h exp=%h", out_data, exp_frame()); end
        checks++; if (out_frame_id !== 8'd0) begin errors++; $display("FAIL basic_id got=%0d exp=0", out_frame_id); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_pad();
        fill(8'h01, 8'h11);
        pz[3] = 2'b10;
        pz[4] = 2'b10;
        send_range(0, 8);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pad_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_frame()) begin errors++; $display("FAIL pad_data got=%h exp=%h", out_data, exp_frame()); end
        checks++; if (out_frame_id !== 8'd1) begin errors++; $display("FAIL pad_id got=%0d exp=1", out_frame_id); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        fill(8'h61, 8'h71);
        send_range(0, 8);
        exp_a = exp_frame();
        fill(8'h81, 8'h91);
        send_range(0, 7);
        checks++; if (out_data !== exp_a) begin errors++; $display("FAIL bp_hold_a got=%h exp=%h", out_data, exp_a); end
        in_valid = 1'b1;
        in_data  = {v1[8], v0[8]};
        pad_zero = pz[8];
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_held_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_a) begin errors++; $display("FAIL bp_held_data got=%h exp=%h", out_data, exp_a); end
        checks++; if (out_frame_id !== 8'd2) begin errors++; $display("FAIL bp_held_id got=%0d exp=2", out_frame_id); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_b_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_frame()) begin errors++; $display("FAIL bp_b_data got=%h exp=%h", out_data, exp_frame()); end
        checks++; if (out_frame_id !== 8'd3) begin errors++; $display("FAIL bp_b_id got=%0d exp=3", out_frame_id); end
        @(negedge clk);
        checks++; if (out_data !== exp_frame()) begin errors++; $display("FAIL bp_b_hold got=%h exp=%h", out_data, exp_frame()); end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
    endtask

    task automatic test_clear();
        fill(8'hA1, 8'hB1);
        send_range(0, 4);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hEEEE;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        fill(8'h21, 8'h51);
        send_range(0, 3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_stale_frame got=%b exp=0", out_valid); end
        send_range(4, 7);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_early got=%b exp=0", out_valid); end
        send_beat(8);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clear_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_frame()) begin errors++; $display("FAIL clear_data got=%h exp=%h", out_data, exp_frame()); end
        checks++; if (out_frame_id !== 8'd4) begin errors++; $display("FAIL clear_id got=%0d exp=4", out_frame_id); end
        @(negedge clk);
    endtask

    task automatic test_pause();
        fill(8'hC1, 8'hD1);
        send_range(0, 5);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        pad_zero = 2'b11;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL pause_ready got=%b exp=0", in_ready); end
        repeat (4) @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        send_range(6, 7);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pause_early got=%b exp=0", out_valid); end
        send_beat(8);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pause_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_frame()) begin errors++; $display("FAIL pause_data got=%h exp=%h", out_data, exp_frame()); end
        checks++; if (out_frame_id !== 8'd5) begin errors++; $display("FAIL pause_id got=%0d exp=5", out_frame_id); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        fill(8'h0F, 8'h1F);
        send_range(0, 5);
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", out_valid); end
        fill(8'h33, 8'h44);
        send_range(0, 7);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_early got=%b exp=0", out_valid); end
        send_beat(8);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_frame_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== exp_frame()) begin errors++; $display("FAIL rmid_data got=%h exp=%h", out_data, exp_frame()); end
        checks++; if (out_frame_id !== 8'd0) begin errors++; $display("FAIL rmid_id got=%0d exp=0", out_frame_id); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pad();
        test_back_to_back();
        test_clear();
        test_pause();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
